data_axi_bridge: RTL and testbench
==================================

# data_axi_bridge

Converts the MEM stage's SRAM-like data port (req/wr/size/addr/wdata, addr_ok/data_ok) into an AXI3 master. Sits directly downstream of the MEM stage's data port, one side per interface. Accepts one transaction at a time and presents read data on data_data_ok. Optionally posts writes, meaning completion is signalled before the B response returns.

## Interface
- RD_ID, default 4'd0: arid value.
- WR_ID, default 4'd1: awid and wid value.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_req / data_wr  in  1/1  request valid; 1 = write.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr / data_wdata  in  32/32  byte address; write data, already lane-aligned.
- data_addr_ok / data_data_ok  out  1/1  request accepted; data returned or write complete.
- data_rdata  out  32  read data, valid only while data_data_ok.
- arid, araddr, arsize, arvalid  out  4/32/3/1  AR channel. araddr = data_addr; arsize = {1'b0, data_size}.
- arready  in  1  AR channel ready.
- rid, rdata, rresp, rlast, rvalid  in  4/32/2/1/1  R channel.
- rready  out  1  R channel ready.
- awid, awaddr, awsize, awvalid  out  4/32/3/1  AW channel; awaddr and awsize use the AR rules.
- awready  in  1  AW channel ready.
- wid, wdata, wstrb, wlast, wvalid  out  4/32/4/1/1  W channel. wlast is constantly 1.
- wready  in  1  W channel ready.
- bid, bresp, bvalid  in  4/2/1  B channel.
- bready  out  1  B channel ready.
- arlen/awlen = 0, arburst/awburst = 2'b01, arlock/awlock = 0, arcache/awcache = 0, arprot/awprot = 0: constant outputs.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR (AW and W in flight), WR_RESP.
- IDLE, acceptance:
  - data_addr_ok = data_req & (state == IDLE) & accept_ok. This is combinational.
  - On accept, latch addr, size and wdata.
  - Read: go to RD_ADDR.
  - Write: go to WR_ADDR.
- RD_ADDR: arvalid = 1 from a register. Hold until arready, then go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - data_data_ok = rvalid, and data_rdata = rdata in the same cycle.
  - Go to IDLE on rvalid.
  - rresp is ignored.
- WR_ADDR:
  - awvalid and wvalid both rise together in the first cycle.
  - Each drops independently after its own handshake; a sticky done flag is kept per channel.
  - The state is left when both flags are set, counting the current cycle's handshakes.
- wstrb by size:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << {addr[1], 1'b0}.
  - Word: 4'b1111.
  - data_size = 3 is treated as word.
- WR_RESP (only exists with WRITE_RESP_WAIT_EN): bready = 1, data_data_ok = bvalid, then go to IDLE.
- accept_ok is always 1 with the macro defined; without it, see Configuration.
- Reset: all valids and readies go to 0, data_*_ok go to 0, state goes to IDLE, the B counter goes to 0. Reset mid-transaction abandons the transaction.

## Timing
- Acceptance is in the same cycle as data_req when IDLE.
- Best-case read: accepted at T0, arvalid at T1, arready at T1, rvalid at T2. data_data_ok at T2. Next accept at T3.
- Best-case write: accept T0, AW and W handshakes at T1, bvalid at T2, data_data_ok at T2.
  - Without the macro, data_data_ok is at T1.
- Exactly one data_data_ok pulse is issued per accepted request.

## Configuration
- WRITE_RESP_WAIT_EN defined:
  - A write completes (data_data_ok) on bvalid.
  - bready is asserted only in WR_RESP.
- Undefined (posted writes):
  - bready is tied to 1.
  - data_data_ok pulses in the cycle both the AW and W handshakes are done, then the FSM goes to IDLE.
  - A 2-bit counter tracks outstanding B responses. It is incremented on completion and decremented on bvalid; a simultaneous increment and decrement leave it unchanged.
  - Reads are accepted only when the counter is 0, to prevent a read-after-write hazard.
  - Writes are accepted only when the counter is below 3.

## Test plan
- Word read at 0x1FC0_0010, arready delayed 3 cycles, rdata = 0xDEAD_BEEF:
  - One addr_ok.
  - arvalid held stable for 4 cycles.
  - data_data_ok = 1 for one cycle, with data_rdata = 0xDEAD_BEEF.
- Byte write to 0x8000_0003, wdata = 0xAB00_0000:
  - wstrb = 4'b1000, awsize = 0.
  - data_data_ok on bvalid (macro on).
- Half write to 0x8000_0002, with wready asserted 2 cycles before awready:
  - wvalid drops after its handshake.
  - Exactly one data_data_ok is produced.
  - wstrb = 4'b1100.
- Macro off: three back-to-back writes with bvalid stalled:
  - The fourth write is not accepted.
  - A read is blocked until all three bvalid pulses arrive.
  - The counter returns to 0.
- rst pulled low while in RD_DATA, then released:
  - All outputs are 0 and the state is IDLE.
  - The next read completes normally.
- Read immediately following a write (macro on):
  - The read is not accepted before the write's data_data_ok.
  - The read is accepted the cycle after.

Source files
------------

// File: rtl/data_axi_bridge.sv
// data_axi_bridge: bridges the MEM-stage SRAM-like data port to an AXI3 master, one transaction at a time.
// Optional feature macro WRITE_RESP_WAIT_EN: writes complete on the B response; undefined, writes are posted.
module data_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_e;

  state_e      state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        accept_ok;
  logic        aw_fire, w_fire, wr_both;

  // IDs, response codes and rlast carry no information for a single-outstanding bridge
  logic unused_axi_fields;
  assign unused_axi_fields = ^{rid, rresp, rlast, bid, bresp};

  assign arlen   = 4'd0;
  assign awlen   = 4'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = 2'd0;
  assign awlock  = 2'd0;
  assign arcache = 4'd0;
  assign awcache = 4'd0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;

  assign arid   = RD_ID;
  assign araddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awid   = WR_ID;
  assign awaddr = addr_q;
  assign awsize = {1'b0, size_q};
  assign wid    = WR_ID;
  assign wdata  = wdata_q;
  assign wlast  = 1'b1;

  assign arvalid = (state_q == RD_ADDR);
  assign rready  = (state_q == RD_DATA);
  assign awvalid = (state_q == WR_ADDR) & ~aw_done_q;
  assign wvalid  = (state_q == WR_ADDR) & ~w_done_q;

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  // Leave WR_ADDR as soon as both channels are done, including handshakes happening this cycle
  assign wr_both = (aw_done_q | aw_fire) & (w_done_q | w_fire);

  assign data_addr_ok = data_req & (state_q == IDLE) & accept_ok;

  always_comb begin
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = 4'b0011 << {addr_q[1], 1'b0};
      default: wstrb = 4'b1111;
    endcase
  end

`ifdef WRITE_RESP_WAIT_EN
  assign accept_ok = 1'b1;
  assign bready    = (state_q == WR_RESP);
`else
  logic [1:0] bcnt_q, bcnt_d;
  logic       bcnt_inc, bcnt_dec;

  // Reads wait for every posted write to be acknowledged; writes stop when the counter is full
  assign accept_ok = data_wr ? (bcnt_q != 2'd3) : (bcnt_q == 2'd0);
  assign bready    = 1'b1;
  assign bcnt_inc  = (state_q == WR_ADDR) & wr_both;
  assign bcnt_dec  = bvalid & (bcnt_q != 2'd0);

  always_comb begin
    bcnt_d = bcnt_q;
    case ({bcnt_inc, bcnt_dec})
      2'b10:   bcnt_d = bcnt_q + 2'd1;
      2'b01:   bcnt_d = bcnt_q - 2'd1;
      default: bcnt_d = bcnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bcnt_q <= 2'd0;
    else      bcnt_q <= bcnt_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    case (state_q)
      IDLE: begin
        if (data_addr_ok) begin
          state_d   = data_wr ? WR_ADDR : RD_ADDR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        data_rdata = rdata;
        if (rvalid) begin
          data_data_ok = 1'b1;
          state_d      = IDLE;
        end
      end
      WR_ADDR: begin
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (wr_both) begin
`ifdef WRITE_RESP_WAIT_EN
          state_d = WR_RESP;
`else
          data_data_ok = 1'b1;
          state_d      = IDLE;
`endif
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          data_data_ok = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Request payload is only meaningful after an accept, so it carries no reset
  always_ff @(posedge clk) begin
    if (data_addr_ok) begin
      addr_q  <= data_addr;
      size_q  <= data_size;
      wdata_q <= data_wdata;
    end
  end

endmodule

// File: tb/tb_data_axi_bridge.sv
// tb_data_axi_bridge: directed scenarios plus a randomized run against a transaction-level model.
// Honours WRITE_RESP_WAIT_EN the same way as the design.
module tb_data_axi_bridge;

`ifdef WRITE_RESP_WAIT_EN
  localparam bit RESP_WAIT = 1'b1;
`else
  localparam bit RESP_WAIT = 1'b0;
`endif
  localparam logic [3:0] RD_ID = 4'd3;
  localparam logic [3:0] WR_ID = 4'd9;

  logic        clk, rst;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int vectors = 0;
  int miscompares = 0;

  data_axi_bridge #(.RD_ID(RD_ID), .WR_ID(WR_ID)) dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = RD_ID; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
    bid = WR_ID; bresp = 2'd0; bvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    vectors++; if ({arvalid, awvalid, wvalid, rready, data_addr_ok, data_data_ok} !== 6'b0) begin miscompares++; $display("FAIL reset_ctrl got %b want 000000", {arvalid, awvalid, wvalid, rready, data_addr_ok, data_data_ok}); end
    vectors++; if (bready !== ~RESP_WAIT) begin miscompares++; $display("FAIL reset_bready got %b want %b", bready, ~RESP_WAIT); end
    vectors++; if ({arlen, awlen, arburst, awburst, arlock, awlock, arcache, awcache, arprot, awprot} !== {4'd0, 4'd0, 2'b01, 2'b01, 2'd0, 2'd0, 4'd0, 4'd0, 3'd0, 3'd0}) begin miscompares++; $display("FAIL const_outputs got %h", {arlen, awlen, arburst, awburst, arlock, awlock, arcache, awcache, arprot, awprot}); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if ({arvalid, awvalid, wvalid, rready, data_addr_ok, data_data_ok, wlast} !== 7'b0000001) begin miscompares++; $display("FAIL post_reset_ctrl got %b want 0000001", {arvalid, awvalid, wvalid, rready, data_addr_ok, data_data_ok, wlast}); end
  endtask

  task automatic test_read_delayed();
    clear_inputs();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1FC0_0010;
    #1;
    vectors++; if (data_addr_ok !== 1'b1) begin miscompares++; $display("FAIL rd_accept got %b want 1", data_addr_ok); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_req = 1'b0;
      arready = (i == 3);
      #1;
      vectors++; if ({arvalid, araddr, arsize, arid, data_data_ok} !== {1'b1, 32'h1FC0_0010, 3'd2, RD_ID, 1'b0}) begin miscompares++; $display("FAIL rd_ar_hold cyc %0d got %h want %h", i, {arvalid, araddr, arsize, arid, data_data_ok}, {1'b1, 32'h1FC0_0010, 3'd2, RD_ID, 1'b0}); end
    end
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    vectors++; if ({arvalid, rready, data_data_ok} !== 3'b011) begin miscompares++; $display("FAIL rd_r_phase got %b want 011", {arvalid, rready, data_data_ok}); end
    vectors++; if (data_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_data got %h want deadbeef", data_rdata); end
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    vectors++; if ({rready, data_data_ok} !== 2'b00) begin miscompares++; $display("FAIL rd_done got %b want 00", {rready, data_data_ok}); end
  endtask

  task automatic test_write_byte();
    clear_inputs();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h8000_0003; data_wdata = 32'hAB00_0000;
    #1;
    vectors++; if (data_addr_ok !== 1'b1) begin miscompares++; $display("FAIL wb_accept got %b want 1", data_addr_ok); end
    @(negedge clk);
    data_req = 1'b0; awready = 1'b1; wready = 1'b1;
    #1;
    vectors++; if ({awvalid, wvalid, awsize, awaddr, awid} !== {1'b1, 1'b1, 3'd0, 32'h8000_0003, WR_ID}) begin miscompares++; $display("FAIL wb_aw got %h want %h", {awvalid, wvalid, awsize, awaddr, awid}, {1'b1, 1'b1, 3'd0, 32'h8000_0003, WR_ID}); end
    vectors++; if ({wstrb, wdata, wid, wlast} !== {4'b1000, 32'hAB00_0000, WR_ID, 1'b1}) begin miscompares++; $display("FAIL wb_w got %h want %h", {wstrb, wdata, wid, wlast}, {4'b1000, 32'hAB00_0000, WR_ID, 1'b1}); end
    vectors++; if (data_data_ok !== ~RESP_WAIT) begin miscompares++; $display("FAIL wb_ok_at_hs got %b want %b", data_data_ok, ~RESP_WAIT); end
    @(negedge clk);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    #1;
    vectors++; if ({awvalid, wvalid, bready} !== 3'b001) begin miscompares++; $display("FAIL wb_b_phase got %b want 001", {awvalid, wvalid, bready}); end
    vectors++; if (data_data_ok !== RESP_WAIT) begin miscompares++; $display("FAIL wb_ok_at_b got %b want %b", data_data_ok, RESP_WAIT); end
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    vectors++; if ({data_data_ok, bready} !== {1'b0, ~RESP_WAIT}) begin miscompares++; $display("FAIL wb_done got %b want %b", {data_data_ok, bready}, {1'b0, ~RESP_WAIT}); end
  endtask

  task automatic test_write_half_w_first();
    int oks;
    logic exp_ok;
    clear_inputs();
    oks = 0;
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h8000_0002; data_wdata = 32'h5A5A_0000;
    #1;
    vectors++; if (data_addr_ok !== 1'b1) begin miscompares++; $display("FAIL wh_accept got %b want 1", data_addr_ok); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      data_req = 1'b0;
      wready = (c == 0); awready = (c == 2); bvalid = (c == 4);
      #1;
      oks += int'(data_data_ok);
      exp_ok = RESP_WAIT ? (c == 4) : (c == 2);
      vectors++; if ({awvalid, wvalid} !== {1'(c <= 2), 1'(c == 0)}) begin miscompares++; $display("FAIL wh_valids cyc %0d got %b want %b", c, {awvalid, wvalid}, {1'(c <= 2), 1'(c == 0)}); end
      vectors++; if (data_data_ok !== exp_ok) begin miscompares++; $display("FAIL wh_ok cyc %0d got %b want %b", c, data_data_ok, exp_ok); end
      if (c == 0) begin
        vectors++; if ({wstrb, awsize} !== {4'b1100, 3'd1}) begin miscompares++; $display("FAIL wh_strb got %h want %h", {wstrb, awsize}, {4'b1100, 3'd1}); end
      end
    end
    vectors++; if (oks != 1) begin miscompares++; $display("FAIL wh_ok_count got %0d want 1", oks); end
  endtask

`ifdef WRITE_RESP_WAIT_EN
  task automatic test_read_after_write();
    clear_inputs();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_0010; data_wdata = $urandom;
    #1;
    vectors++; if (data_addr_ok !== 1'b1) begin miscompares++; $display("FAIL raw_wr_accept got %b want 1", data_addr_ok); end
    @(negedge clk);
    data_wr = 1'b0; data_addr = 32'h1FC0_0020; awready = 1'b1; wready = 1'b1;
    #1;
    vectors++; if ({data_addr_ok, data_data_ok} !== 2'b00) begin miscompares++; $display("FAIL raw_hs got %b want 00", {data_addr_ok, data_data_ok}); end
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    #1;
    vectors++; if ({data_addr_ok, data_data_ok, bready} !== 3'b001) begin miscompares++; $display("FAIL raw_wait_b got %b want 001", {data_addr_ok, data_data_ok, bready}); end
    @(negedge clk);
    bvalid = 1'b1;
    #1;
    vectors++; if ({data_addr_ok, data_data_ok} !== 2'b01) begin miscompares++; $display("FAIL raw_b got %b want 01", {data_addr_ok, data_data_ok}); end
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    vectors++; if (data_addr_ok !== 1'b1) begin miscompares++; $display("FAIL raw_rd_accept got %b want 1", data_addr_ok); end
    @(negedge clk);
    data_req = 1'b0; arready = 1'b1;
    #1;
    vectors++; if ({arvalid, araddr} !== {1'b1, 32'h1FC0_0020}) begin miscompares++; $display("FAIL raw_ar got %h want %h", {arvalid, araddr}, {1'b1, 32'h1FC0_0020}); end
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1357_9BDF;
    #1;
    vectors++; if ({data_data_ok, data_rdata} !== {1'b1, 32'h1357_9BDF}) begin miscompares++; $display("FAIL raw_r got %h want %h", {data_data_ok, data_rdata}, {1'b1, 32'h1357_9BDF}); end
    @(negedge clk);
    rvalid = 1'b0;
  endtask
`else
  task automatic test_posted_limit();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_0100 + 32'(4 * k); data_wdata = $urandom;
      awready = 1'b0; wready = 1'b0;
      #1;
      vectors++; if (data_addr_ok !== 1'b1) begin miscompares++; $display("FAIL pw_accept %0d got %b want 1", k, data_addr_ok); end
      @(negedge clk);
      awready = 1'b1; wready = 1'b1;
      #1;
      vectors++; if ({data_data_ok, data_addr_ok} !== 2'b10) begin miscompares++; $display("FAIL pw_complete %0d got %b want 10", k, {data_data_ok, data_addr_ok}); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      awready = 1'b0; wready = 1'b0;
      #1;
      vectors++; if (data_addr_ok !== 1'b0) begin miscompares++; $display("FAIL pw_fourth_blocked got %b want 0", data_addr_ok); end
    end
    @(negedge clk);
    data_wr = 1'b0; data_addr = 32'h1FC0_0040;
    #1;
    vectors++; if (data_addr_ok !== 1'b0) begin miscompares++; $display("FAIL pw_read_blocked got %b want 0", data_addr_ok); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bvalid = 1'b1;
      #1;
      vectors++; if (data_addr_ok !== 1'b0) begin miscompares++; $display("FAIL pw_read_wait %0d got %b want 0", j, data_addr_ok); end
      @(negedge clk);
      bvalid = 1'b0;
      #1;
      vectors++; if (data_addr_ok !== 1'(j == 2)) begin miscompares++; $display("FAIL pw_read_release %0d got %b want %b", j, data_addr_ok, 1'(j == 2)); end
    end
    @(negedge clk);
    data_req = 1'b0; arready = 1'b1;
    #1;
    vectors++; if ({arvalid, araddr} !== {1'b1, 32'h1FC0_0040}) begin miscompares++; $display("FAIL pw_ar got %h want %h", {arvalid, araddr}, {1'b1, 32'h1FC0_0040}); end
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_F00D;
    #1;
    vectors++; if ({data_data_ok, data_rdata} !== {1'b1, 32'h0BAD_F00D}) begin miscompares++; $display("FAIL pw_r got %h want %h", {data_data_ok, data_rdata}, {1'b1, 32'h0BAD_F00D}); end
    @(negedge clk);
    rvalid = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_read();
    logic [31:0] rv;
    clear_inputs();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1FC0_0080;
    #1;
    vectors++; if (data_addr_ok !== 1'b1) begin miscompares++; $display("FAIL rst_rd_accept got %b want 1", data_addr_ok); end
    @(negedge clk);
    data_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    #1;
    vectors++; if (rready !== 1'b1) begin miscompares++; $display("FAIL rst_in_rdata got %b want 1", rready); end
    #2;
    rst = 1'b0; rvalid = 1'b1;
    #1;
    vectors++; if ({arvalid, awvalid, wvalid, rready, data_addr_ok, data_data_ok, bready} !== {6'b0, ~RESP_WAIT}) begin miscompares++; $display("FAIL rst_mid got %b want %b", {arvalid, awvalid, wvalid, rready, data_addr_ok, data_data_ok, bready}, {6'b0, ~RESP_WAIT}); end
    @(negedge clk);
    rvalid = 1'b0; rst = 1'b1;
    #1;
    vectors++; if ({arvalid, rready, data_data_ok} !== 3'b000) begin miscompares++; $display("FAIL rst_release got %b want 000", {arvalid, rready, data_data_ok}); end
    @(negedge clk);
    data_req = 1'b1; data_addr = 32'h1FC0_0084;
    #1;
    vectors++; if (data_addr_ok !== 1'b1) begin miscompares++; $display("FAIL rst_next_accept got %b want 1", data_addr_ok); end
    @(negedge clk);
    data_req = 1'b0; arready = 1'b1;
    #1;
    vectors++; if ({arvalid, araddr} !== {1'b1, 32'h1FC0_0084}) begin miscompares++; $display("FAIL rst_next_ar got %h want %h", {arvalid, araddr}, {1'b1, 32'h1FC0_0084}); end
    @(negedge clk);
    rv = $urandom;
    arready = 1'b0; rvalid = 1'b1; rdata = rv;
    #1;
    vectors++; if ({data_data_ok, data_rdata} !== {1'b1, rv}) begin miscompares++; $display("FAIL rst_next_r got %h want %h", {data_data_ok, data_rdata}, {1'b1, rv}); end
    @(negedge clk);
    rvalid = 1'b0;
  endtask

  // Model tracks the open transaction as a set of outstanding channel obligations
  task automatic test_random(input int ncyc);
    bit          act, twr, ar_done, aw_done, w_done, b_phase;
    logic [31:0] taddr, twdata;
    logic [1:0]  tsize;
    int          b_pend, nbytes, base;
    logic        acc, e_aok, e_dok, e_arv, e_rr, e_awv, e_wv, e_br, aw_f, w_f, both, bfire;
    logic [3:0]  e_strb;
    clear_inputs();
    act = 0; twr = 0; ar_done = 0; aw_done = 0; w_done = 0; b_phase = 0;
    taddr = 32'd0; twdata = 32'd0; tsize = 2'd0; b_pend = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      data_req   = ($urandom_range(0, 2) != 0);
      data_wr    = 1'($urandom_range(0, 1));
      data_size  = 2'($urandom_range(0, 3));
      data_addr  = $urandom;
      data_wdata = $urandom;
      arready    = 1'($urandom_range(0, 1));
      awready    = 1'($urandom_range(0, 1));
      wready     = 1'($urandom_range(0, 1));
      rvalid     = act && !twr && ar_done && ($urandom_range(0, 1) == 1);
      rdata      = $urandom;
      rresp      = 2'($urandom_range(0, 3));
      bvalid     = (b_pend > 0) && ($urandom_range(0, 2) == 0);
      bresp      = 2'($urandom_range(0, 3));
      #1;
      if (RESP_WAIT) acc = 1'b1;
      else           acc = data_wr ? (b_pend < 3) : (b_pend == 0);
      e_aok = data_req && !act && acc;
      e_arv = act && !twr && !ar_done;
      e_rr  = act && !twr && ar_done;
      e_awv = act && twr && !b_phase && !aw_done;
      e_wv  = act && twr && !b_phase && !w_done;
      e_br  = RESP_WAIT ? b_phase : 1'b1;
      aw_f  = e_awv && awready;
      w_f   = e_wv && wready;
      both  = act && twr && !b_phase && (aw_done || aw_f) && (w_done || w_f);
      bfire = bvalid && e_br;
      e_dok = (e_rr && rvalid) || (RESP_WAIT ? (b_phase && bvalid) : both);
      nbytes = (tsize == 2'd0) ? 1 : (tsize == 2'd1) ? 2 : 4;
      base   = (int'(taddr[1:0]) / nbytes) * nbytes;
      e_strb = 4'(((1 << nbytes) - 1) << base);
      vectors++; if ({data_addr_ok, data_data_ok, arvalid, rready, awvalid, wvalid, bready} !== {e_aok, e_dok, e_arv, e_rr, e_awv, e_wv, e_br}) begin miscompares++; $display("FAIL rnd_ctrl cyc %0d got %b want %b", c, {data_addr_ok, data_data_ok, arvalid, rready, awvalid, wvalid, bready}, {e_aok, e_dok, e_arv, e_rr, e_awv, e_wv, e_br}); end
      if (e_arv) begin
        vectors++; if ({araddr, arsize, arid} !== {taddr, 1'b0, tsize, RD_ID}) begin miscompares++; $display("FAIL rnd_ar cyc %0d got %h want %h", c, {araddr, arsize, arid}, {taddr, 1'b0, tsize, RD_ID}); end
      end
      if (e_awv) begin
        vectors++; if ({awaddr, awsize, awid} !== {taddr, 1'b0, tsize, WR_ID}) begin miscompares++; $display("FAIL rnd_aw cyc %0d got %h want %h", c, {awaddr, awsize, awid}, {taddr, 1'b0, tsize, WR_ID}); end
      end
      if (e_wv) begin
        vectors++; if ({wdata, wstrb, wid, wlast} !== {twdata, e_strb, WR_ID, 1'b1}) begin miscompares++; $display("FAIL rnd_w cyc %0d got %h want %h", c, {wdata, wstrb, wid, wlast}, {twdata, e_strb, WR_ID, 1'b1}); end
      end
      if (e_rr && rvalid) begin
        vectors++; if (data_rdata !== rdata) begin miscompares++; $display("FAIL rnd_rdata cyc %0d got %h want %h", c, data_rdata, rdata); end
      end
      if (e_arv && arready) ar_done = 1;
      if (e_rr && rvalid) act = 0;
      if (aw_f) aw_done = 1;
      if (w_f) w_done = 1;
      if (bfire) begin
        b_pend--;
        if (RESP_WAIT) begin b_phase = 0; act = 0; end
      end
      if (both) begin
        b_pend++;
        if (RESP_WAIT) b_phase = 1;
        else act = 0;
      end
      if (e_aok) begin
        act = 1; twr = data_wr; taddr = data_addr; tsize = data_size; twdata = data_wdata;
        ar_done = 0; aw_done = 0; w_done = 0; b_phase = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_read_delayed();
    test_write_byte();
    test_write_half_w_first();
`ifdef WRITE_RESP_WAIT_EN
    test_read_after_write();
`else
    test_posted_limit();
`endif
    test_reset_mid_read();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
